// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Sequential shift-add multiplier. One multiplier bit is
//               consumed per RUN cycle (LSB first), so a product takes WIDTH
//               RUN cycles plus one DONE cycle before the next start is
//               accepted.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH   : operand width in bits (2..32), default 16
// Ports
//   clk     : in  1        rising-edge clock
//   rst     : in  1        asynchronous active-high reset
//   start   : in  1        begin a multiply (accepted only while ready)
//   inputP  : in  WIDTH    multiplicand, captured on an accepted start
//   inputQ  : in  WIDTH    multiplier, captured on an accepted start
//   ready   : out 1        IDLE, a start will be accepted
//   busy    : out 1        RUN, multiply in progress
//   done    : out 1        one-cycle pulse, product holds a new result
//   product : out 2*WIDTH  result of the last completed multiply
// Configuration
//   SEQ_MULT_SIGNED_EN : when defined, operands and product are two's
//                        complement; otherwise everything is unsigned.
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   inputP,
  input  logic [WIDTH-1:0]   inputQ,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_mcand;     // multiplicand, shifted left each step
  logic [WIDTH-1:0]   r_mplier;    // multiplier, shifted right each step
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   w_p_op;
  logic [WIDTH-1:0]   w_q_op;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_result;

  // The final step's addition is folded into the product write so the
  // result lands on the same edge that enters DONE.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign w_p_op   = inputP[WIDTH-1] ? (WIDTH'(0) - inputP) : inputP;
  assign w_q_op   = inputQ[WIDTH-1] ? (WIDTH'(0) - inputQ) : inputQ;
  assign w_result = r_neg ? ((2*WIDTH)'(0) - w_acc_next) : w_acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_neg <= inputP[WIDTH-1] ^ inputQ[WIDTH-1];
    end
  end
`else
  assign w_p_op   = inputP;
  assign w_q_op   = inputQ;
  assign w_result = w_acc_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      product  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_p_op};
            r_mplier <= w_q_op;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            product <= w_result;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);

endmodule
`default_nettype wire
